// File: rtl/lif_slot_scheduler.sv
// ---------------------------------------------------------------------------
// lif_slot_scheduler
//
// Time-multiplexed controller for one shared leaky-integrate-and-fire unit.
// It holds membrane potential (V), pending input current (pend) and the
// refractory count (ref) for 8 neurons. One neuron is updated per enabled,
// unstalled cycle, visiting the slots in round-robin order 0..7.
//
// Handshakes (both ports): a transfer happens on a rising edge where
// valid && ready are both high. valid never depends on ready. Once raised,
// spike_valid and spike_idx hold until that transfer. An undelivered event
// stalls the slot sequence, so a new fire can never overwrite it.
//
// Parameters
//   LEAK_SHIFT  leak term is V >> LEAK_SHIFT (1..7)
//   REFRAC      rounds a neuron is skipped after firing (0..7)
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   en           slot sequencing enable; 0 freezes slot/V/ref
//   in_valid     current write request
//   in_ready     write accepted when in_valid && in_ready (low in reset)
//   in_idx       target neuron of the write
//   in_current   unsigned current added (saturating) to pend[in_idx]
//   thr_we       load global threshold from thr_data
//   thr_data     new threshold value
//   spike_valid  spike event available
//   spike_ready  consumer accepts the event
//   spike_idx    neuron that fired
//   state        post-update V of the neuron processed in the last update
//   slot         neuron the next update cycle will process
//   round_done   one-cycle pulse after slot 7 has been processed
// ---------------------------------------------------------------------------
module lif_slot_scheduler #(
  parameter int unsigned LEAK_SHIFT = 3,
  parameter int unsigned REFRAC     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_idx,
  input  logic [7:0] in_current,
  input  logic       thr_we,
  input  logic [7:0] thr_data,
  output logic       spike_valid,
  input  logic       spike_ready,
  output logic [2:0] spike_idx,
  output logic [7:0] state,
  output logic [2:0] slot,
  output logic       round_done
);

  localparam logic [2:0] REFRAC_L  = 3'(REFRAC);
  localparam logic [7:0] THR_RESET = 8'h7F;

  // Per-neuron storage
  logic [7:0] v_q    [8];
  logic [7:0] v_d    [8];
  logic [7:0] pend_q [8];
  logic [7:0] pend_d [8];
  logic [2:0] ref_q  [8];
  logic [2:0] ref_d  [8];

  // Global / output registers
  logic [7:0] thr_q,         thr_d;
  logic [2:0] slot_q,        slot_d;
  logic [7:0] state_q,       state_d;
  logic       spike_valid_q, spike_valid_d;
  logic [2:0] spike_idx_q,   spike_idx_d;
  logic       round_done_q,  round_done_d;

  // Datapath signals for the neuron in the current slot
  logic       wr_acc;
  logic       stall;
  logic       upd;
  logic [7:0] v_cur;
  logic [7:0] pend_cur;
  logic [2:0] ref_cur;
  logic       in_refrac;
  logic [7:0] leaked;
  logic [8:0] sum9;
  logic [7:0] v_int;
  logic       fire;
  logic [7:0] v_new;
  logic [8:0] pend_sum [8];

  // Writes are refused only while reset is held.
  assign in_ready = rst_n;

  assign wr_acc = in_valid && in_ready;
  assign stall  = spike_valid_q && !spike_ready;
  assign upd    = en && !stall;

  assign v_cur     = v_q[slot_q];
  assign pend_cur  = pend_q[slot_q];
  assign ref_cur   = ref_q[slot_q];
  assign in_refrac = (ref_cur != 3'd0);

  // V - (V >> k) never underflows, so only the add needs a carry bit.
  assign leaked = v_cur - (v_cur >> LEAK_SHIFT);
  assign sum9   = {1'b0, leaked} + {1'b0, pend_cur};
  assign v_int  = sum9[8] ? 8'hFF : sum9[7:0];
  assign fire   = !in_refrac && (v_int >= thr_q);
  assign v_new  = (in_refrac || fire) ? 8'd0 : v_int;

  // Saturating accumulate of an incoming write, per neuron.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      pend_sum[i] = {1'b0, pend_q[i]} + {1'b0, in_current};
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      v_d[i]    = v_q[i];
      ref_d[i]  = ref_q[i];
      pend_d[i] = pend_q[i];

      if (wr_acc && (in_idx == 3'(i))) begin
        pend_d[i] = pend_sum[i][8] ? 8'hFF : pend_sum[i][7:0];
      end

      if (upd && (slot_q == 3'(i))) begin
        v_d[i] = v_new;
        if (in_refrac) begin
          ref_d[i] = ref_cur - 3'd1;
        end else if (fire) begin
          ref_d[i] = REFRAC_L;
        end
        // The update consumes the old pend; a same-cycle write becomes the
        // fresh pend value for the next round.
        if (wr_acc && (in_idx == 3'(i))) begin
          pend_d[i] = in_current;
        end else begin
          pend_d[i] = 8'd0;
        end
      end
    end
  end

  always_comb begin
    thr_d         = thr_q;
    slot_d        = slot_q;
    state_d       = state_q;
    spike_valid_d = spike_valid_q;
    spike_idx_d   = spike_idx_q;
    round_done_d  = 1'b0;

    if (thr_we) begin
      thr_d = thr_data;
    end

    // Delivery first; a new fire in the same cycle overrides the clear so
    // the next event is presented without a bubble.
    if (spike_valid_q && spike_ready) begin
      spike_valid_d = 1'b0;
    end

    if (upd) begin
      state_d      = v_new;
      slot_d       = slot_q + 3'd1;
      round_done_d = (slot_q == 3'd7);
      if (fire) begin
        spike_valid_d = 1'b1;
        spike_idx_d   = slot_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        v_q[i]    <= 8'd0;
        pend_q[i] <= 8'd0;
        ref_q[i]  <= 3'd0;
      end
      thr_q         <= THR_RESET;
      slot_q        <= 3'd0;
      state_q       <= 8'd0;
      spike_valid_q <= 1'b0;
      spike_idx_q   <= 3'd0;
      round_done_q  <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        v_q[i]    <= v_d[i];
        pend_q[i] <= pend_d[i];
        ref_q[i]  <= ref_d[i];
      end
      thr_q         <= thr_d;
      slot_q        <= slot_d;
      state_q       <= state_d;
      spike_valid_q <= spike_valid_d;
      spike_idx_q   <= spike_idx_d;
      round_done_q  <= round_done_d;
    end
  end

  assign spike_valid = spike_valid_q;
  assign spike_idx   = spike_idx_q;
  assign state       = state_q;
  assign slot        = slot_q;
  assign round_done  = round_done_q;

endmodule

// File: tb/tb_lif_slot_scheduler.sv
// ---------------------------------------------------------------------------
// tb_lif_slot_scheduler
//
// Directed bench for lif_slot_scheduler (LEAK_SHIFT=3, REFRAC=2). Each task
// drives one scenario and checks outputs one time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_lif_slot_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_idx;
  logic [7:0] in_current;
  logic       thr_we;
  logic [7:0] thr_data;
  logic       spike_valid;
  logic       spike_ready;
  logic [2:0] spike_idx;
  logic [7:0] state;
  logic [2:0] slot;
  logic       round_done;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_leak [4] = '{8'd64, 8'd56, 8'd49, 8'd43};

  lif_slot_scheduler #(.LEAK_SHIFT(3), .REFRAC(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_idx     (in_idx),
    .in_current (in_current),
    .thr_we     (thr_we),
    .thr_data   (thr_data),
    .spike_valid(spike_valid),
    .spike_ready(spike_ready),
    .spike_idx  (spike_idx),
    .state      (state),
    .slot       (slot),
    .round_done (round_done)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n       = 1'b0;
    en          = 1'b0;
    in_valid    = 1'b0;
    in_idx      = 3'd0;
    in_current  = 8'd0;
    thr_we      = 1'b0;
    thr_data    = 8'd0;
    spike_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic write_cur(input logic [2:0] idx, input logic [7:0] cur);
    in_valid   = 1'b1;
    in_idx     = idx;
    in_current = cur;
    step();
    in_valid = 1'b0;
  endtask

  task automatic load_thr(input logic [7:0] d);
    thr_we   = 1'b1;
    thr_data = d;
    step();
    thr_we = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    apply_reset();
    rst_n = 1'b0;
    step();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
    total++; if (slot !== 3'd0) begin bad++; $display("FAIL reset_slot: got %0d want 0", slot); end
    total++; if (state !== 8'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
    total++; if (spike_valid !== 1'b0) begin bad++; $display("FAIL reset_spike_valid: got %0b want 0", spike_valid); end
    total++; if (spike_idx !== 3'd0) begin bad++; $display("FAIL reset_spike_idx: got %0d want 0", spike_idx); end
    total++; if (round_done !== 1'b0) begin bad++; $display("FAIL reset_round_done: got %0b want 0", round_done); end
    rst_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready: got %0b want 1", in_ready); end
    // Threshold reset value 0x7F: 126 stays below, 127 fires.
    write_cur(3'd0, 8'h7E);
    write_cur(3'd1, 8'h7F);
    en = 1'b1;
    step();
    total++; if (state !== 8'd126) begin bad++; $display("FAIL thr_reset_below_state: got %0d want 126", state); end
    total++; if (spike_valid !== 1'b0) begin bad++; $display("FAIL thr_reset_below_spike: got %0b want 0", spike_valid); end
    step();
    total++; if (spike_valid !== 1'b1 || spike_idx !== 3'd1) begin bad++; $display("FAIL thr_reset_equal_spike: got v=%0b i=%0d want v=1 i=1", spike_valid, spike_idx); end
    en = 1'b0;
  endtask

  task automatic test_fire();
    logic [2:0] es;
    apply_reset();
    write_cur(3'd2, 8'h80);
    en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      es = 3'(k + 1);
      total++; if (spike_valid !== (k == 2)) begin bad++; $display("FAIL fire_spike_valid k=%0d: got %0b want %0b", k, spike_valid, (k == 2)); end
      total++; if (slot !== es) begin bad++; $display("FAIL fire_slot k=%0d: got %0d want %0d", k, slot, es); end
      total++; if (state !== 8'd0) begin bad++; $display("FAIL fire_state k=%0d: got %0d want 0", k, state); end
      total++; if (round_done !== (k == 7)) begin bad++; $display("FAIL fire_round_done k=%0d: got %0b want %0b", k, round_done, (k == 7)); end
      if (k == 2) begin
        total++; if (spike_idx !== 3'd2) begin bad++; $display("FAIL fire_spike_idx: got %0d want 2", spike_idx); end
      end
    end
    en = 1'b0;
  endtask

  task automatic test_leak();
    apply_reset();
    write_cur(3'd0, 8'h40);
    en = 1'b1;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 8; k++) begin
        step();
        if (k == 0) begin
          total++; if (state !== exp_leak[r]) begin bad++; $display("FAIL leak_state round=%0d: got %0d want %0d", r, state, exp_leak[r]); end
        end
      end
    end
    en = 1'b0;
  endtask

  task automatic test_saturation();
    apply_reset();
    load_thr(8'hFF);
    write_cur(3'd5, 8'hF0);
    write_cur(3'd5, 8'h20);
    en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      if (k == 4) begin
        total++; if (spike_valid !== 1'b0) begin bad++; $display("FAIL sat_no_early_spike: got %0b want 0", spike_valid); end
      end
    end
    total++; if (spike_valid !== 1'b1 || spike_idx !== 3'd5) begin bad++; $display("FAIL sat_fire: got v=%0b i=%0d want v=1 i=5", spike_valid, spike_idx); end
    en = 1'b0;
  endtask

  task automatic test_refractory();
    logic ev;
    apply_reset();
    en = 1'b1;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 8; k++) begin
        if (k == 0) begin
          in_valid   = 1'b1;
          in_idx     = 3'd3;
          in_current = 8'hFF;
        end
        step();
        in_valid = 1'b0;
        if (k == 3) begin
          ev = (r == 0) || (r == 3);
          total++; if (spike_valid !== ev) begin bad++; $display("FAIL refrac_spike round=%0d: got %0b want %0b", r, spike_valid, ev); end
          total++; if (state !== 8'd0) begin bad++; $display("FAIL refrac_state round=%0d: got %0d want 0", r, state); end
        end
      end
    end
    en = 1'b0;
  endtask

  task automatic test_backpressure();
    apply_reset();
    write_cur(3'd1, 8'h80);
    spike_ready = 1'b0;
    en = 1'b1;
    step();
    step();
    total++; if (spike_valid !== 1'b1 || spike_idx !== 3'd1 || slot !== 3'd2) begin bad++; $display("FAIL bp_fire: got v=%0b i=%0d s=%0d want v=1 i=1 s=2", spike_valid, spike_idx, slot); end
    for (int c = 0; c < 5; c++) begin
      if (c == 0) begin
        in_valid   = 1'b1;
        in_idx     = 3'd2;
        in_current = 8'h10;
      end
      step();
      in_valid = 1'b0;
      total++; if (slot !== 3'd2) begin bad++; $display("FAIL bp_slot_hold c=%0d: got %0d want 2", c, slot); end
      total++; if (spike_valid !== 1'b1 || spike_idx !== 3'd1) begin bad++; $display("FAIL bp_spike_hold c=%0d: got v=%0b i=%0d want v=1 i=1", c, spike_valid, spike_idx); end
      total++; if (round_done !== 1'b0) begin bad++; $display("FAIL bp_round_done c=%0d: got %0b want 0", c, round_done); end
    end
    spike_ready = 1'b1;
    step();
    total++; if (slot !== 3'd3) begin bad++; $display("FAIL bp_resume_slot: got %0d want 3", slot); end
    total++; if (spike_valid !== 1'b0) begin bad++; $display("FAIL bp_resume_spike: got %0b want 0", spike_valid); end
    total++; if (state !== 8'd16) begin bad++; $display("FAIL bp_resume_state: got %0d want 16", state); end
    en = 1'b0;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    write_cur(3'd1, 8'h80);
    write_cur(3'd2, 8'h80);
    spike_ready = 1'b1;
    en = 1'b1;
    step();
    step();
    total++; if (spike_valid !== 1'b1 || spike_idx !== 3'd1) begin bad++; $display("FAIL b2b_first: got v=%0b i=%0d want v=1 i=1", spike_valid, spike_idx); end
    step();
    total++; if (spike_valid !== 1'b1 || spike_idx !== 3'd2) begin bad++; $display("FAIL b2b_second: got v=%0b i=%0d want v=1 i=2", spike_valid, spike_idx); end
    step();
    total++; if (spike_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain: got %0b want 0", spike_valid); end
    en = 1'b0;
  endtask

  task automatic test_same_cycle_and_hold();
    apply_reset();
    write_cur(3'd0, 8'h10);
    en         = 1'b1;
    in_valid   = 1'b1;
    in_idx     = 3'd0;
    in_current = 8'h20;
    step();
    in_valid = 1'b0;
    total++; if (state !== 8'd16) begin bad++; $display("FAIL samecyc_old_pend: got %0d want 16", state); end
    en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      total++; if (slot !== 3'd1) begin bad++; $display("FAIL hold_slot c=%0d: got %0d want 1", c, slot); end
      total++; if (round_done !== 1'b0) begin bad++; $display("FAIL hold_round_done c=%0d: got %0b want 0", c, round_done); end
    end
    write_cur(3'd1, 8'h05);
    en = 1'b1;
    step();
    total++; if (state !== 8'd5) begin bad++; $display("FAIL hold_write_state: got %0d want 5", state); end
    for (int k = 2; k < 8; k++) step();
    total++; if (round_done !== 1'b1) begin bad++; $display("FAIL hold_round_done_pulse: got %0b want 1", round_done); end
    step();
    total++; if (state !== 8'd46) begin bad++; $display("FAIL samecyc_new_pend: got %0d want 46", state); end
    total++; if (round_done !== 1'b0) begin bad++; $display("FAIL round_done_single: got %0b want 0", round_done); end
    en = 1'b0;
  endtask

  task automatic test_threshold();
    logic [2:0] s;
    logic       ev;
    apply_reset();
    write_cur(3'd0, 8'h50);
    write_cur(3'd1, 8'h10);
    en       = 1'b1;
    thr_we   = 1'b1;
    thr_data = 8'h10;
    step();
    thr_we = 1'b0;
    total++; if (state !== 8'd80 || spike_valid !== 1'b0) begin bad++; $display("FAIL thr_old_value: got st=%0d v=%0b want st=80 v=0", state, spike_valid); end
    step();
    total++; if (spike_valid !== 1'b1 || spike_idx !== 3'd1) begin bad++; $display("FAIL thr_new_value: got v=%0b i=%0d want v=1 i=1", spike_valid, spike_idx); end
    en = 1'b0;
    load_thr(8'h00);
    en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      s = 3'(k + 2);
      ev = (s != 3'd1);
      step();
      total++; if (spike_valid !== ev) begin bad++; $display("FAIL thr_zero_spike slot=%0d: got %0b want %0b", s, spike_valid, ev); end
      if (ev) begin
        total++; if (spike_idx !== s) begin bad++; $display("FAIL thr_zero_idx slot=%0d: got %0d want %0d", s, spike_idx, s); end
      end
    end
    en = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    load_thr(8'h80);
    write_cur(3'd0, 8'h20);
    write_cur(3'd3, 8'h80);
    spike_ready = 1'b0;
    en = 1'b1;
    for (int k = 0; k < 4; k++) step();
    total++; if (spike_valid !== 1'b1 || spike_idx !== 3'd3 || slot !== 3'd4) begin bad++; $display("FAIL rmid_pre: got v=%0b i=%0d s=%0d want v=1 i=3 s=4", spike_valid, spike_idx, slot); end
    rst_n = 1'b0;
    step();
    total++; if (slot !== 3'd0) begin bad++; $display("FAIL rmid_slot: got %0d want 0", slot); end
    total++; if (spike_valid !== 1'b0) begin bad++; $display("FAIL rmid_spike_valid: got %0b want 0", spike_valid); end
    total++; if (state !== 8'd0) begin bad++; $display("FAIL rmid_state: got %0d want 0", state); end
    total++; if (spike_idx !== 3'd0) begin bad++; $display("FAIL rmid_spike_idx: got %0d want 0", spike_idx); end
    rst_n = 1'b1;
    spike_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      total++; if (spike_valid !== 1'b0 || state !== 8'd0) begin bad++; $display("FAIL rmid_quiet k=%0d: got v=%0b st=%0d want v=0 st=0", k, spike_valid, state); end
    end
    en = 1'b0;
    write_cur(3'd0, 8'h7F);
    en = 1'b1;
    step();
    total++; if (spike_valid !== 1'b1 || spike_idx !== 3'd0) begin bad++; $display("FAIL rmid_thr_reset: got v=%0b i=%0d want v=1 i=0", spike_valid, spike_idx); end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fire();
    test_leak();
    test_saturation();
    test_refractory();
    test_backpressure();
    test_back_to_back();
    test_same_cycle_and_hold();
    test_threshold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lif_slot_scheduler.md
# lif_slot_scheduler

Time-multiplexed controller for the shared leaky-integrate-and-fire update datapath. It owns membrane potential, pending input current and refractory count for 8 neurons, and sequences one neuron per cycle through a single leak/integrate/fire unit in round-robin slot order. Input currents arrive over a valid/ready write port. Spike events leave over a valid/ready event port whose backpressure stalls the slot sequence.

## Interface
- `LEAK_SHIFT`, default 3: leak is `V >> LEAK_SHIFT`, legal range 1..7.
- `REFRAC`, default 2: number of rounds a neuron is skipped after firing, legal range 0..7.
- `clk` input 1: single clock, all logic on rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `en` input 1: slot sequencing enable; when 0, no updates occur and the slot holds.
- `in_valid` input 1: current write request.
- `in_ready` output 1: write accepted when `in_valid && in_ready`.
- `in_idx` input 3: target neuron of the write.
- `in_current` input 8: unsigned current added to that neuron's pending accumulator.
- `thr_we` input 1: load the global threshold.
- `thr_data` input 8: new threshold value.
- `spike_valid` output 1: spike event available.
- `spike_ready` input 1: consumer accepts the event.
- `spike_idx` output 3: index of the neuron that fired.
- `state` output 8: post-update membrane potential of the neuron processed in the last update cycle.
- `slot` output 3: index of the neuron the next update cycle will process.
- `round_done` output 1: one-cycle pulse after slot 7 is processed.

## Operation
- Per-neuron registers: `V[8]`, `pend[8]`, `ref[8]` (3 bits each). Global register `thr`.
- Reset values:
  - `V`, `pend`, `ref`, `slot`, `state`: 0.
  - `thr`: 8'h7F.
  - `spike_valid`, `round_done`: 0.
  - `spike_idx`: 0.
  - `in_ready`: 0 while `rst_n` = 0, otherwise 1.
- Write port: an accepted write sets `pend[in_idx] = min(pend[in_idx] + in_current, 255)`, computed at 9 bits and saturated.
- Stall: `stall = spike_valid && !spike_ready`.
- Update cycle: occurs when `en && !stall`, and processes neuron `s = slot`.
- Refractory branch, taken if `ref[s] != 0`:
  - `ref[s]--`; `V[s]` stays 0; `pend[s]` cleared (current discarded); no spike.
- Integrate branch, otherwise:
  - `v = V[s] - (V[s] >> LEAK_SHIFT) + pend[s]`, computed at 9 bits and saturated to 255.
  - `pend[s]` cleared.
  - If `v >= thr`: fire. Set `V[s] = 0`, `ref[s] = REFRAC`, load `spike_valid = 1` and `spike_idx = s`.
  - Otherwise `V[s] = v`.
- Outputs after each update cycle:
  - `state` = new `V[s]`.
  - `slot` advances: 7 wraps to 0.
  - `round_done` = 1 when s = 7.
- Write to `s` in the same cycle as its update: the update consumes the old `pend[s]`, and the new `pend[s]` becomes the `in_current` written (saturation not applicable).
- Spike port:
  - `spike_valid` clears on a handshake unless a new fire loads it in the same cycle. A handshake and a new fire in the same cycle present the new event next cycle, with no bubble.
  - Events are never dropped or overwritten.
- Threshold:
  - `thr_we` takes effect for update cycles starting the next cycle.
  - `thr` = 0 makes every non-refractory update fire.
- `en` = 0 or a stall: `slot`, `V`, `ref` hold. Writes and threshold loads still proceed. `round_done` = 0.
- Reset asserted mid-operation: all state returns to reset values at that edge, and any pending spike is lost.

## Timing
- Update latency: an update at edge t makes `state`, `spike_valid` and `spike_idx` visible after edge t.
- Round period: 8 update cycles with no stalls.
- Current written before the update edge of its slot is integrated in that round.
- Refractory: a neuron that fires in round r is skipped in rounds r+1..r+REFRAC and integrates again in round r+REFRAC+1.
- Backpressure: with `spike_ready` low after a fire, `slot` freezes at s+1 until the handshake cycle. It resumes updating in that same cycle.

## Test plan
- Fire: reset, then write 0x80 to neuron 2, `en` = 1. Required: at slot 2, `state` = 0, `spike_valid` = 1, `spike_idx` = 2. All other slots produce no spike.
- Leak: write 0x40 to neuron 0 only. Required: `state` at slot 0 reads 64, 56, 49, 43 over four rounds.
- Saturation: write 0xF0 then 0x20 to neuron 5, `thr` = 0xFF. Required: fire at slot 5 with `spike_idx` = 5, since pend saturates to 255 and 255 >= 255.
- Refractory (REFRAC = 2): write 0xFF to neuron 3 every round. Required: spike in round 0, none in rounds 1–2 (`state` = 0), spike again in round 3.
- Backpressure: `spike_ready` = 0 while neuron 1 fires. Required: `slot` holds at 2 and `spike_idx` holds at 1 for 5 cycles. On raising `spike_ready`, the handshake completes and slot 2 is processed in the same cycle.
- Reset mid-round: assert `rst_n` = 0 at slot 4 with `spike_valid` = 1. Required: next cycle shows `slot` = 0, `spike_valid` = 0, `state` = 0, `thr` = 0x7F. The first post-reset round produces no spikes without new writes.
